// File: rtl/add_window_acc.sv
// Windowed accumulator for a 17-bit signed adder stream: sums 2^WIN_LOG2 samples exactly and
// holds the window sum and floored mean until the result is taken. Optional mean saturation: ADD_WINDOW_ACC_SAT_EN.
module add_window_acc #(
  parameter int WIN_LOG2 = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic signed [16:0]         in_sum,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic signed [16+WIN_LOG2:0] out_acc,
  output logic signed [15:0]         out_mean,
  output logic                       out_sat
);

  localparam int ACC_W = 17 + WIN_LOG2;
  localparam int CNT_W = WIN_LOG2 + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((1 << WIN_LOG2) - 1);

  typedef enum logic [1:0] {IDLE, ACC, HOLD} state_e;

  state_e                    state_q, state_d;
  logic [CNT_W-1:0]          count_q, count_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic signed [ACC_W-1:0]   out_acc_q, out_acc_d;
  logic signed [15:0]        out_mean_q, out_mean_d;
  logic                      out_sat_q, out_sat_d;

  logic                      accept;
  logic signed [ACC_W-1:0]   sum_ext;
  logic signed [ACC_W-1:0]   acc_next;
  logic signed [15:0]        mean_fit;
  logic                      sat_fit;

  assign in_ready  = (state_q != HOLD);
  // clear drops a concurrent sample even though in_ready stays high
  assign accept    = in_valid & in_ready & ~clear;
  assign sum_ext   = {{WIN_LOG2{in_sum[16]}}, in_sum};
  assign acc_next  = (state_q == IDLE) ? sum_ext : acc_q + sum_ext;

`ifdef ADD_WINDOW_ACC_SAT_EN
  logic signed [16:0] mean17;
  // Slicing above the low WIN_LOG2 bits is the floor (arithmetic) shift.
  assign mean17   = acc_next[WIN_LOG2 +: 17];
  assign sat_fit  = mean17[16] ^ mean17[15];
  assign mean_fit = sat_fit ? (mean17[16] ? 16'sh8000 : 16'sh7FFF) : mean17[15:0];
`else
  assign mean_fit = acc_next[WIN_LOG2 +: 16];
  assign sat_fit  = 1'b0;
`endif

  // NOTE: every output of this block gets a default first, so no path leaves a latch.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    acc_d      = acc_q;
    out_acc_d  = out_acc_q;
    out_mean_d = out_mean_q;
    out_sat_d  = out_sat_q;
    if (clear) begin
      state_d = IDLE;
      count_d = '0;
      acc_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: if (accept) begin
          acc_d   = acc_next;
          count_d = CNT_W'(1);
          state_d = ACC;
        end
        ACC: if (accept) begin
          acc_d   = acc_next;
          count_d = count_q + CNT_W'(1);
          if (count_q == LAST_CNT) begin
            state_d    = HOLD;
            out_acc_d  = acc_next;
            out_mean_d = mean_fit;
            out_sat_d  = sat_fit;
          end
        end
        HOLD: if (out_ready) begin
          state_d = IDLE;
          count_d = '0;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      count_q    <= '0;
      acc_q      <= '0;
      out_acc_q  <= '0;
      out_mean_q <= '0;
      out_sat_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      acc_q      <= acc_d;
      out_acc_q  <= out_acc_d;
      out_mean_q <= out_mean_d;
      out_sat_q  <= out_sat_d;
    end
  end

  assign out_valid = (state_q == HOLD);
  assign out_acc   = out_acc_q;
  assign out_mean  = out_mean_q;
  assign out_sat   = out_sat_q;

endmodule
